// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, immediate codes, control bit indices and FSM states
// Purpose: common definitions for the ID-stage controller and its main decoder.
// Ports: none (package).
package cpu_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] IMM_NONE = 2'd0;
  localparam logic [1:0] IMM_I    = 2'd1;
  localparam logic [1:0] IMM_S    = 2'd2;
  localparam logic [1:0] IMM_B    = 2'd3;

  // Bit positions inside the ID/EX control bundle
  // {rsvd, alu_op[1:0], alu_src, mem_write, mem_read, mem_to_reg, reg_write}
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_ALU_OP_LO  = 5;
  localparam int CTRL_ALU_OP_HI  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/cpu_main_decoder.sv
// rtl/cpu_main_decoder.sv - combinational opcode decoder for the ID stage
// Purpose: maps an opcode to the control bundle, immediate format and operand usage.
// Ports:
//   opcode   in  7       instruction opcode field
//   ctrl     out CTRL_W  control bundle for ID/EX
//   imm_sel  out 2       immediate format select
//   uses_rs2 out 1       instruction reads rs2
//   illegal  out 1       opcode not recognised
module cpu_main_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 8
) (
  input  logic [6:0]        opcode,
  output logic [CTRL_W-1:0] ctrl,
  output logic [1:0]        imm_sel,
  output logic              uses_rs2,
  output logic              illegal
);

  always_comb begin
    ctrl     = '0;
    imm_sel  = IMM_NONE;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_OP_HI] = 1'b1;
        uses_rs2             = 1'b1;
      end
      OP_I: begin
        imm_sel              = IMM_I;
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[CTRL_ALU_OP_HI] = 1'b1;
      end
      OP_LD: begin
        imm_sel               = IMM_I;
        ctrl[CTRL_REG_WRITE]  = 1'b1;
        ctrl[CTRL_MEM_READ]   = 1'b1;
        ctrl[CTRL_MEM_TO_REG] = 1'b1;
        ctrl[CTRL_ALU_SRC]    = 1'b1;
      end
      OP_SD: begin
        imm_sel              = IMM_S;
        ctrl[CTRL_MEM_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        uses_rs2             = 1'b1;
      end
      OP_BEQ: begin
        imm_sel              = IMM_B;
        ctrl[CTRL_ALU_OP_LO] = 1'b1;
        uses_rs2             = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage decode, hazard detection and front-end sequencing
// Purpose: decodes the IF/ID instruction, tracks ID/EX and EX/MEM shadows, stalls on
//   load-use and branch-operand hazards, resolves BEQ in ID and runs IDLE/RUN/ERR.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               leave IDLE when high
//   inst_i, inst_valid_i  IF/ID instruction and its valid flag
//   branch_eq_i           rs1==rs2 from the ID comparator
//   imm_sel_o             immediate format (combinational)
//   pc_write_o, ifid_write_o, ifid_flush_o, branch_taken_o  front-end controls
//   ex_ctrl_o, ex_rd_o    registered ID/EX control bundle and destination
//   illegal_o             sticky illegal-opcode flag
//   stall_cnt_o           saturating stall-cycle count
module id_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CTRL_W   = 8,
  parameter int STALL_CW = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [31:0]         inst_i,
  input  logic                inst_valid_i,
  input  logic                branch_eq_i,
  output logic [1:0]          imm_sel_o,
  output logic                pc_write_o,
  output logic                ifid_write_o,
  output logic                ifid_flush_o,
  output logic                branch_taken_o,
  output logic [CTRL_W-1:0]   ex_ctrl_o,
  output logic [4:0]          ex_rd_o,
  output logic                illegal_o,
  output logic [STALL_CW-1:0] stall_cnt_o
);

  state_t              state, state_next;
  logic [CTRL_W-1:0]   dec_ctrl;
  logic                dec_uses_rs2;
  logic                dec_illegal;
  logic                mem_read_q;
  logic [4:0]          mem_rd_q;
  logic [4:0]          rs1, rs2, rd;
  logic                is_beq, active, issue;
  logic                match_ex, match_mem;
  logic                h_load_use, h_br_alu, h_br_load, stall;
  logic                unused_inst_bits;

  assign rs1 = inst_i[19:15];
  assign rs2 = inst_i[24:20];
  assign rd  = inst_i[11:7];
  assign unused_inst_bits = ^{inst_i[31:25], inst_i[14:12]};

  cpu_main_decoder #(.CTRL_W(CTRL_W)) u_dec (
    .opcode   (inst_i[6:0]),
    .ctrl     (dec_ctrl),
    .imm_sel  (imm_sel_o),
    .uses_rs2 (dec_uses_rs2),
    .illegal  (dec_illegal)
  );

  // An illegal opcode reads no registers, so it can never match a producer.
  assign match_ex  = (ex_rd_o != 5'd0) && !dec_illegal &&
                     ((ex_rd_o == rs1) || (dec_uses_rs2 && (ex_rd_o == rs2)));
  assign match_mem = (mem_rd_q != 5'd0) && !dec_illegal &&
                     ((mem_rd_q == rs1) || (dec_uses_rs2 && (mem_rd_q == rs2)));

  assign is_beq     = (inst_i[6:0] == OP_BEQ);
  assign active     = (state == ST_RUN) && inst_valid_i;
  assign h_load_use = ex_ctrl_o[CTRL_MEM_READ] && match_ex;
  assign h_br_alu   = is_beq && ex_ctrl_o[CTRL_REG_WRITE] && !ex_ctrl_o[CTRL_MEM_READ] && match_ex;
  assign h_br_load  = is_beq && mem_read_q && match_mem;
  assign stall      = active && (h_load_use || h_br_alu || h_br_load);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    pc_write_o     = 1'b0;
    ifid_write_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    branch_taken_o = 1'b0;
    issue          = 1'b0;
    case (state)
      ST_IDLE: if (start_i) state_next = ST_RUN;
      ST_RUN: begin
        pc_write_o   = !stall;
        ifid_write_o = !stall;
        // Stall wins over a taken branch: the BEQ is re-evaluated once operands are ready.
        if (active && is_beq && branch_eq_i && !stall) begin
          branch_taken_o = 1'b1;
          ifid_flush_o   = 1'b1;
        end
        if (active && dec_illegal) state_next = ST_ERR;
        issue = active && !stall && !dec_illegal;
      end
      ST_ERR: ;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_ctrl_o   <= '0;
      ex_rd_o     <= '0;
      mem_read_q  <= 1'b0;
      mem_rd_q    <= '0;
      illegal_o   <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      // EX/MEM always drains ID/EX; outside RUN ID/EX only ever holds bubbles.
      mem_read_q <= ex_ctrl_o[CTRL_MEM_READ];
      mem_rd_q   <= ex_rd_o;
      if (issue) begin
        ex_ctrl_o <= dec_ctrl;
        ex_rd_o   <= rd;
      end else begin
        ex_ctrl_o <= '0;
        ex_rd_o   <= '0;
      end
      if (stall && (stall_cnt_o != {STALL_CW{1'b1}}))
        stall_cnt_o <= stall_cnt_o + {{(STALL_CW-1){1'b0}}, 1'b1};
      if ((state == ST_RUN) && (state_next == ST_ERR))
        illegal_o <= 1'b1;
    end
  end

endmodule
